// File: rtl/anim_datapath.sv
// anim_datapath -- pixel generator for a falling-sprite animation.
//
// Sweeps the whole 160x120 screen in the background colour, then draws
// a 4x4 sprite at a pseudo-random column and moves it down one row per
// animation frame (erase old position, step, redraw) until the sprite
// reaches the bottom row.
//
// Ports
//   clk       in   single clock, all state on the rising edge
//   reset     in   asynchronous, active-high reset
//   ld_BG     in   held high while the background sweep is wanted
//   ld_coord  in   one-cycle request to latch a new sprite start location
//   ld_plot   in   held high while the animation runs
//   x         out  [7:0] pixel column 0..159 (registered)
//   y         out  [6:0] pixel row 0..119 (registered)
//   colour    out  [2:0] pixel colour (registered)
//   plot      out  pixel write strobe; x/y/colour valid only when high
//   draw      out  one-cycle pulse, background sweep complete
//   cleared   out  one-cycle pulse, erase of previous sprite complete
//   done      out  one-cycle pulse, sprite reached the bottom row
module anim_datapath #(
    parameter int unsigned FRAME_DIV     = 833333,
    parameter logic [2:0]  BG_COLOUR     = 3'b001,
    parameter logic [2:0]  SPRITE_COLOUR = 3'b100,
    parameter logic [7:0]  SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_BG,
    input  logic       ld_coord,
    input  logic       ld_plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       draw,
    output logic       cleared,
    output logic       done
);

    localparam int unsigned CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_DIV - 1);

    localparam logic [7:0] X_LAST   = 8'd159;
    localparam logic [6:0] Y_LAST   = 7'd119;
    localparam logic [6:0] Y_BOTTOM = 7'd116;   // top row of a sprite on the last screen row

    typedef enum logic [2:0] {
        IDLE, BG, BG_END, WAIT, ERASE, MOVE, SPRITE, FIN
    } state_t;

    state_t        state;
    logic [7:0]    spr_x;       // sprite top-left column
    logic [6:0]    spr_y;       // sprite top-left row
    logic [3:0]    off;         // pixel inside the 4x4 block: [1:0] column, [3:2] row
    logic [CW-1:0] frame_cnt;
    logic [7:0]    lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    logic       lfsr_fb;
    logic [7:0] start_x;
    logic [3:0] off_inc;
    logic [7:0] blk_x;
    logic [6:0] blk_y;

    always_comb begin
        lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        // Keep the 4-wide sprite on screen: columns above 156 fold back by 100.
        start_x = (lfsr <= 8'd156) ? lfsr : lfsr - 8'd100;
        off_inc = off + 4'd1;
        blk_x   = spr_x + {6'd0, off_inc[1:0]};
        blk_y   = spr_y + {5'd0, off_inc[3:2]};
    end

    // NOTE: every register below is updated with <= so all of them see the
    // pre-edge values; mixing in = here would make results order-dependent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            draw      <= 1'b0;
            cleared   <= 1'b0;
            done      <= 1'b0;
            spr_x     <= '0;
            spr_y     <= '0;
            off       <= '0;
            frame_cnt <= '0;
            lfsr      <= SEED;
        end else begin
            lfsr    <= {lfsr[6:0], lfsr_fb};
            // Status strobes are single-cycle unless re-asserted below.
            draw    <= 1'b0;
            cleared <= 1'b0;
            done    <= 1'b0;

            if (ld_BG && state != BG) begin
                // Background request overrides anything else in progress.
                state  <= BG;
                x      <= '0;
                y      <= '0;
                colour <= BG_COLOUR;
                plot   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        plot <= 1'b0;
                        if (ld_coord) begin
                            spr_x     <= start_x;
                            spr_y     <= '0;
                            frame_cnt <= '0;
                        end else if (ld_plot) begin
                            // Initial draw: no erase of a previous position.
                            state  <= SPRITE;
                            off    <= '0;
                            x      <= spr_x;
                            y      <= spr_y;
                            colour <= SPRITE_COLOUR;
                            plot   <= 1'b1;
                        end
                    end

                    BG: begin
                        if (!ld_BG) begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end else if (x == X_LAST && y == Y_LAST) begin
                            state <= BG_END;
                            plot  <= 1'b0;
                            draw  <= 1'b1;
                        end else if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 7'd1;
                        end else begin
                            x <= x + 8'd1;
                        end
                    end

                    WAIT: begin
                        if (!ld_plot) begin
                            state <= IDLE;
                        end else if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            state     <= ERASE;
                            off       <= '0;
                            x         <= spr_x;
                            y         <= spr_y;
                            colour    <= BG_COLOUR;
                            plot      <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end

                    ERASE: begin
                        if (!ld_plot) begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end else if (off == 4'hF) begin
                            state   <= MOVE;
                            plot    <= 1'b0;
                            cleared <= 1'b1;
                        end else begin
                            off <= off_inc;
                            x   <= blk_x;
                            y   <= blk_y;
                        end
                    end

                    MOVE: begin
                        if (!ld_plot) begin
                            state <= IDLE;
                        end else begin
                            spr_y  <= spr_y + 7'd1;
                            state  <= SPRITE;
                            off    <= '0;
                            x      <= spr_x;
                            y      <= spr_y + 7'd1;
                            colour <= SPRITE_COLOUR;
                            plot   <= 1'b1;
                        end
                    end

                    SPRITE: begin
                        if (!ld_plot) begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end else if (off == 4'hF) begin
                            plot <= 1'b0;
                            if (spr_y == Y_BOTTOM) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state     <= WAIT;
                                frame_cnt <= '0;
                            end
                        end else begin
                            off <= off_inc;
                            x   <= blk_x;
                            y   <= blk_y;
                        end
                    end

                    // BG_END and FIN: single pulse cycle, then back to IDLE.
                    default: begin
                        state <= IDLE;
                        plot  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_anim_datapath.sv
// tb_anim_datapath -- directed self-checking bench for anim_datapath.
// Runs with FRAME_DIV=4 and SEED=200 so sprite columns are easy to
// derive by hand: first LFSR value 200 -> column 100, the next value
// 144 (200 shifted with feedback 0) -> column 144.
module tb_anim_datapath;

    localparam logic [2:0] BG_C  = 3'b001;
    localparam logic [2:0] SPR_C = 3'b100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ld_BG = 1'b0;
    logic       ld_coord = 1'b0;
    logic       ld_plot = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, draw, cleared, done;

    int n_checks = 0;
    int n_pass = 0;
    int pulse_bad = 0;

    anim_datapath #(
        .FRAME_DIV    (4),
        .BG_COLOUR    (BG_C),
        .SPRITE_COLOUR(SPR_C),
        .SEED         (8'd200)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ld_BG   (ld_BG),
        .ld_coord(ld_coord),
        .ld_plot (ld_plot),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .draw    (draw),
        .cleared (cleared),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Status pulses must be mutually exclusive and never overlap a plot.
    always @(negedge clk) begin
        if (!reset && (($countones({draw, cleared, done}) > 1) ||
                       (plot && (draw || cleared || done))))
            pulse_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Hold reset across two edges; returns at the negedge where it is released.
    task automatic do_reset(input logic coord);
        @(negedge clk);
        reset    = 1'b1;
        ld_BG    = 1'b0;
        ld_plot  = 1'b0;
        ld_coord = coord;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered at the negedge showing pixel (0,0); checks the whole sweep,
    // the draw pulse, and drops ld_BG.
    task automatic bg_sweep(input string tag);
        int bad;
        logic [18:0] exp_v;
        for (int r = 0; r < 120; r++) begin
            bad = 0;
            for (int c = 0; c < 160; c++) begin
                exp_v = {1'b1, BG_C, 8'(c), 7'(r)};
                if ({plot, colour, x, y} !== exp_v) bad++;
                @(negedge clk);
            end
            check($sformatf("%s_row%0d", tag, r), bad, 0);
        end
        check({tag, "_draw"}, {plot, draw}, 2'b01);
        ld_BG = 1'b0;
        @(negedge clk);
        check({tag, "_draw_once"}, {plot, draw}, 2'b00);
    endtask

    // Entered at the negedge showing the first block pixel; leaves at the
    // negedge of the cycle after the 16th pixel.
    task automatic expect_block(input int bx, input int by, input logic [2:0] col, input string tag);
        int bad;
        logic [18:0] exp_v;
        bad = 0;
        for (int oy = 0; oy < 4; oy++) begin
            for (int ox = 0; ox < 4; ox++) begin
                exp_v = {1'b1, col, 8'(bx + ox), 7'(by + oy)};
                if ({plot, colour, x, y} !== exp_v) bad++;
                @(negedge clk);
            end
        end
        check($sformatf("%s_y%0d", tag, by), bad, 0);
    endtask

    task automatic expect_gap(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if ({plot, draw, cleared, done} !== 4'b0000) bad++;
            @(negedge clk);
        end
        check(tag, bad, 0);
    endtask

    initial begin
        // ---- reset state ----
        @(negedge clk);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_flags", {plot, draw, cleared, done}, 0);

        // ---- full background sweep ----
        do_reset(1'b0);
        ld_BG = 1'b1;
        @(negedge clk);
        check("bg_first", {plot, colour, x, y}, {1'b1, BG_C, 8'd0, 7'd0});
        bg_sweep("bg");

        // ---- reset in the middle of a sweep ----
        do_reset(1'b0);
        ld_BG = 1'b1;
        @(negedge clk);
        repeat (60 * 160 + 80) @(negedge clk);
        check("mid_pixel", {plot, x, y}, {1'b1, 8'd80, 7'd60});
        #2 reset = 1'b1;
        ld_BG = 1'b0;
        #1;
        check("async_rst_xyc", {x, y, colour}, 0);
        check("async_rst_flags", {plot, draw, cleared, done}, 0);
        @(negedge clk);
        reset = 1'b0;
        ld_BG = 1'b1;
        @(negedge clk);
        check("restart_origin", {plot, colour, x, y}, {1'b1, BG_C, 8'd0, 7'd0});
        // Dropping ld_BG abandons the sweep; the next request starts over.
        ld_BG = 1'b0;
        @(negedge clk);
        check("bg_abort", {plot, draw}, 2'b00);
        @(negedge clk);
        ld_BG = 1'b1;
        @(negedge clk);
        check("bg_restart_origin", {plot, x, y}, {1'b1, 8'd0, 7'd0});
        ld_BG = 1'b0;
        @(negedge clk);

        // ---- second LFSR value 144 (no fold), abort in SPRITE ----
        do_reset(1'b1);
        @(negedge clk);              // coord latched from 200
        @(negedge clk);              // coord latched from 144
        ld_coord = 1'b0;
        ld_plot  = 1'b1;
        @(negedge clk);
        check("x144_first", {plot, colour, x, y}, {1'b1, SPR_C, 8'd144, 7'd0});
        @(negedge clk);
        check("x144_second", {x, y}, {8'd145, 7'd0});
        ld_plot = 1'b0;
        @(negedge clk);
        check("sprite_abort", {plot, draw, cleared, done}, 4'b0000);

        // ---- full animation: X=100, 116 moves ----
        do_reset(1'b1);
        @(negedge clk);
        ld_coord = 1'b0;
        ld_plot  = 1'b1;
        @(negedge clk);
        for (int r = 0; r <= 116; r++) begin
            expect_block(100, r, SPR_C, "sprite");
            if (r == 116) break;
            expect_gap(4, $sformatf("wait_y%0d", r));
            expect_block(100, r, BG_C, "erase");
            check($sformatf("move_y%0d", r), {plot, draw, cleared, done}, 4'b0010);
            @(negedge clk);
        end
        check("done_pulse", {plot, draw, cleared, done}, 4'b0001);
        ld_plot = 1'b0;
        @(negedge clk);
        check("done_once", {plot, draw, cleared, done}, 4'b0000);

        // ---- drop ld_plot during ERASE ----
        do_reset(1'b1);
        @(negedge clk);
        ld_coord = 1'b0;
        ld_plot  = 1'b1;
        @(negedge clk);
        expect_block(100, 0, SPR_C, "abort_sprite");
        expect_gap(4, "abort_wait");
        check("erase_first", {plot, colour, x, y}, {1'b1, BG_C, 8'd100, 7'd0});
        repeat (2) @(negedge clk);
        ld_plot = 1'b0;
        @(negedge clk);
        expect_gap(20, "erase_abort_idle");

        // ---- ld_BG during WAIT ----
        do_reset(1'b1);
        @(negedge clk);
        ld_coord = 1'b0;
        ld_plot  = 1'b1;
        @(negedge clk);
        expect_block(100, 0, SPR_C, "bgwait_sprite");
        @(negedge clk);
        ld_BG   = 1'b1;
        ld_plot = 1'b0;
        @(negedge clk);
        check("bgwait_first", {plot, colour, x, y}, {1'b1, BG_C, 8'd0, 7'd0});
        bg_sweep("bgwait");

        check("pulse_exclusive", pulse_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/anim_datapath.md
ANIM_DATAPATH -- requirements
Module: anim_datapath

Interface
REQ-001 Parameter FRAME_DIV, 833333: clock cycles per animation frame tick (>=2).
REQ-002 Parameter BG_COLOUR, 3'b001: background fill and erase colour.
REQ-003 Parameter SPRITE_COLOUR, 3'b100: sprite colour.
REQ-004 Parameter SEED, 8'hA5: LFSR reset value (nonzero).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ld_BG  input  1  held high by the controller while the background is to be drawn.
REQ-008 ld_coord  input  1  one-cycle request to latch a new sprite start location.
REQ-009 ld_plot  input  1  held high by the controller while the animation runs.
REQ-010 x  output  8  pixel column, 0..159, registered.
REQ-011 y  output  7  pixel row, 0..119, registered.
REQ-012 colour  output  3  pixel colour, registered.
REQ-013 plot  output  1  pixel write strobe; x/y/colour valid only when high.
REQ-014 draw  output  1  one-cycle pulse: background sweep complete.
REQ-015 cleared  output  1  one-cycle pulse: erase of the previous sprite position complete.
REQ-016 done  output  1  one-cycle pulse: sprite has reached the bottom row.

Function
REQ-017 States: IDLE, BG, BG_END, WAIT, ERASE, MOVE, SPRITE, FIN; the block SHALL use no other states.
REQ-018 IDLE: ld_BG high -> BG; else ld_coord high -> latch location, stay IDLE; else ld_plot high -> SPRITE (initial draw, no erase).
REQ-019 BG: one pixel per cycle, x fast 0..159, y slow 0..119, colour=BG_COLOUR, plot=1; first pixel (0,0) the cycle after ld_BG is first sampled high.
REQ-020 After pixel (159,119) (19200th plot cycle) -> BG_END: plot=0, draw=1 for exactly one cycle, then IDLE.
REQ-021 LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle after reset.
REQ-022 On ld_coord: sprite X = LFSR if LFSR<=156, else LFSR-100; sprite Y = 0; frame counter cleared.
REQ-023 Sprite: 4x4 block at (X..X+3, Y..Y+3); 16 plot cycles, x-offset fast 0..3, y-offset slow 0..3.
REQ-024 SPRITE colour=SPRITE_COLOUR; after 16th pixel: Y==116 -> FIN, else WAIT.
REQ-025 WAIT: plot=0; frame counter counts 0..FRAME_DIV-1; at FRAME_DIV-1 -> ERASE, counter wraps to 0.
REQ-026 ERASE: 16 pixels at current (X,Y), colour=BG_COLOUR; cleared=1 in the cycle following the 16th pixel, which is the MOVE cycle.
REQ-027 MOVE: one cycle, plot=0, Y<=Y+1, then SPRITE; sprite reaches Y=116 after 116 moves.
REQ-028 FIN: plot=0, done=1 for exactly one cycle, then IDLE; X/Y retained.
REQ-029 ld_plot sampled low in WAIT/ERASE/MOVE/SPRITE -> IDLE next cycle, plot=0, no done/cleared pulse.
REQ-030 ld_BG sampled high in any non-BG state -> abort current activity, restart BG at (0,0).
REQ-031 ld_BG low during BG -> IDLE next cycle, no draw pulse; next ld_BG restarts at (0,0).
REQ-032 Priority when simultaneous: reset > ld_BG > ld_coord > ld_plot.
REQ-033 ld_coord outside IDLE SHALL be ignored.
REQ-034 draw, cleared, done SHALL never be high in the same cycle, and never high while plot=1.

Reset
REQ-035 reset high SHALL immediately force state=IDLE, x=0, y=0, colour=0, plot=0, draw=0, cleared=0, done=0, X=0, Y=0, frame counter=0, LFSR=SEED.
REQ-036 Reset asserted mid-sweep or mid-animation SHALL discard progress; first activity after release restarts from the beginning.

Verification
REQ-037 Reset, hold ld_BG -> exactly 19200 plot cycles, first (0,0) last (159,119) colour 001, then draw=1 one cycle.
REQ-038 FRAME_DIV=4, ld_coord with LFSR=200 then ld_plot held -> X=100, Y=0; 16 pixels colour 100 at x 100..103, y 0..3.
REQ-039 Same run -> each step: 4 idle cycles, 16 erase pixels colour 001, cleared pulse, 16 draw pixels one row lower; done after 116th move at Y=116.
REQ-040 Drop ld_plot during ERASE -> plot=0 next cycle, no cleared, no done, state IDLE.
REQ-041 Assert ld_BG during WAIT -> next plot is (0,0) colour 001; sweep completes with draw pulse.
REQ-042 Assert reset at BG pixel (80,60) -> all outputs 0 asynchronously; after release, ld_BG restarts at (0,0).
